// File: rtl/stack_mem_ctrl_if.sv
// Request/response and stack-memory signal bundle for stack_mem_ctrl.
// slave  : controller view (takes requests, drives responses and memory address/write).
// master : environment view (datapath issuing requests plus the data memory).
interface stack_mem_ctrl_if;
    // request channel
    logic        req_valid;
    logic [1:0]  req_op;
    logic [15:0] req_wdata;
    logic        req_ready;
    // response channel (no backpressure)
    logic        rsp_valid;
    logic [15:0] rsp_top;
    logic [15:0] rsp_second;
    logic        err_ovf;
    logic        err_unf;
    logic [14:0] depth;
    // data memory port
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_wea;
    logic [15:0] mem_douta;
    logic [15:0] mem_doutb;

    modport slave (
        input  req_valid, req_op, req_wdata, mem_douta, mem_doutb,
        output req_ready, rsp_valid, rsp_top, rsp_second, err_ovf, err_unf,
               depth, mem_addr, mem_din, mem_wea
    );

    modport master (
        output req_valid, req_op, req_wdata, mem_douta, mem_doutb,
        input  req_ready, rsp_valid, rsp_top, rsp_second, err_ovf, err_unf,
               depth, mem_addr, mem_din, mem_wea
    );
endinterface

// File: rtl/stack_mem_ctrl.sv
// Stack controller: owns sp/depth, drives the stack memory port, returns top two words.
// Latency: PUSH and rejected ops respond 1 cycle after accept, POP/POP2/PEEK2 after 2.
// Backpressure: req_ready only in IDLE (one op in flight); responses cannot be stalled.
//
// Ports: clk, reset (async, active-high); bus (stack_mem_ctrl_if.slave) carries
//   req_valid/req_op/req_wdata/req_ready, rsp_valid/rsp_top/rsp_second, err_ovf/err_unf,
//   depth, mem_addr/mem_din/mem_wea and mem_douta/mem_doutb (word at addr / addr-1).
// Build option: define STACK_MEM_CTRL_STICKY_ERR_EN to make err_ovf/err_unf hold until reset.
module stack_mem_ctrl #(
    parameter logic [15:0] STACK_BASE = 16'h0000,
    parameter int          DEPTH      = 16384
) (
    input  logic          clk,
    input  logic          reset,
    stack_mem_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_RESP  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_PUSH  = 2'b00,
        OP_POP   = 2'b01,
        OP_POP2  = 2'b10,
        OP_PEEK2 = 2'b11
    } op_t;

`ifdef STACK_MEM_CTRL_STICKY_ERR_EN
    localparam bit STICKY_ERR = 1'b1;
`else
    localparam bit STICKY_ERR = 1'b0;
`endif

    // Empty stack points one below the base slot (wraps to 14'h3FFF at base 0).
    localparam logic [13:0] SP_RESET  = STACK_BASE[13:0] - 14'd1;
    localparam logic [14:0] DEPTH_MAX = 15'(DEPTH);

    state_t      state_q;
    op_t         op_q;
    logic [13:0] sp_q;
    logic [14:0] depth_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_top_q;
    logic [15:0] rsp_second_q;
    logic        err_ovf_q;
    logic        err_unf_q;
    logic [13:0] mem_addr_q;
    logic [15:0] mem_din_q;
    logic        mem_wea_q;

    op_t         req_op_d;
    logic        accept_d;
    logic        overflow_d;
    logic        underflow_d;
    logic [13:0] sp_inc_d;
    logic [14:0] depth_inc_d;
    logic [13:0] sp_pop_d;
    logic [14:0] depth_pop_d;

    always_comb begin
        req_op_d    = op_t'(bus.req_op);
        accept_d    = bus.req_valid & req_ready_q;
        overflow_d  = (req_op_d == OP_PUSH) && (depth_q == DEPTH_MAX);
        underflow_d = ((req_op_d == OP_POP) && (depth_q == 15'd0)) ||
                      (((req_op_d == OP_POP2) || (req_op_d == OP_PEEK2)) && (depth_q < 15'd2));
        sp_inc_d    = sp_q + 14'd1;
        depth_inc_d = depth_q + 15'd1;
        // Post-read pointer/count: PEEK2 leaves the stack untouched.
        sp_pop_d    = sp_q;
        depth_pop_d = depth_q;
        case (op_q)
            OP_POP: begin
                sp_pop_d    = sp_q - 14'd1;
                depth_pop_d = depth_q - 15'd1;
            end
            OP_POP2: begin
                sp_pop_d    = sp_q - 14'd2;
                depth_pop_d = depth_q - 15'd2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= OP_PUSH;
            sp_q         <= SP_RESET;
            depth_q      <= 15'd0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_top_q    <= 16'd0;
            rsp_second_q <= 16'd0;
            err_ovf_q    <= 1'b0;
            err_unf_q    <= 1'b0;
            mem_addr_q   <= SP_RESET;
            mem_din_q    <= 16'd0;
            mem_wea_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    rsp_valid_q <= 1'b0;
                    mem_wea_q   <= 1'b0;
                    mem_addr_q  <= sp_q;
                    if (accept_d) begin
                        op_q        <= req_op_d;
                        req_ready_q <= 1'b0;
                        if (overflow_d || underflow_d) begin
                            // Rejected: flag only, memory and pointers untouched.
                            state_q      <= S_ERR;
                            rsp_valid_q  <= 1'b1;
                            rsp_top_q    <= 16'd0;
                            rsp_second_q <= 16'd0;
                            err_ovf_q    <= overflow_d  | (STICKY_ERR & err_ovf_q);
                            err_unf_q    <= underflow_d | (STICKY_ERR & err_unf_q);
                        end else if (req_op_d == OP_PUSH) begin
                            // Write strobe and response both land in the WRITE cycle.
                            state_q      <= S_WRITE;
                            rsp_valid_q  <= 1'b1;
                            rsp_top_q    <= 16'd0;
                            rsp_second_q <= 16'd0;
                            mem_addr_q   <= sp_inc_d;
                            mem_din_q    <= bus.req_wdata;
                            mem_wea_q    <= 1'b1;
                        end else begin
                            state_q <= S_READ;
                        end
                    end
                end

                S_WRITE: begin
                    state_q     <= S_IDLE;
                    sp_q        <= sp_inc_d;
                    depth_q     <= depth_inc_d;
                    mem_addr_q  <= sp_inc_d;
                    mem_wea_q   <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end

                S_READ: begin
                    // Address was already sp; memory output is valid next cycle.
                    state_q     <= S_RESP;
                    rsp_valid_q <= 1'b1;
                end

                S_RESP: begin
                    // Keep the returned words visible until the next response.
                    state_q      <= S_IDLE;
                    rsp_valid_q  <= 1'b0;
                    rsp_top_q    <= bus.mem_douta;
                    rsp_second_q <= (op_q == OP_POP) ? 16'd0 : bus.mem_doutb;
                    sp_q         <= sp_pop_d;
                    depth_q      <= depth_pop_d;
                    mem_addr_q   <= sp_pop_d;
                    req_ready_q  <= 1'b1;
                end

                S_ERR: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    if (!STICKY_ERR) begin
                        err_ovf_q <= 1'b0;
                        err_unf_q <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                    mem_wea_q   <= 1'b0;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // In RESP the memory words are passed straight through; afterwards the
    // captured copies hold the response data.
    always_comb begin
        bus.rsp_top    = rsp_top_q;
        bus.rsp_second = rsp_second_q;
        if (state_q == S_RESP) begin
            bus.rsp_top    = bus.mem_douta;
            bus.rsp_second = (op_q == OP_POP) ? 16'd0 : bus.mem_doutb;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.err_ovf   = err_ovf_q;
    assign bus.err_unf   = err_unf_q;
    assign bus.depth     = depth_q;
    assign bus.mem_addr  = {2'b00, mem_addr_q};
    assign bus.mem_din   = mem_din_q;
    assign bus.mem_wea   = mem_wea_q;

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Bench for stack_mem_ctrl (DEPTH=4, base 0): directed ops, response/write scoreboards.
module tb_stack_mem_ctrl;

`ifdef STACK_MEM_CTRL_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    localparam logic [1:0] PUSH = 2'b00, POP = 2'b01, POP2 = 2'b10, PEEK2 = 2'b11;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic acc_ovf = 1'b0;
    logic acc_unf = 1'b0;

    stack_mem_ctrl_if bus ();

    stack_mem_ctrl #(.STACK_BASE(16'h0000), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read data memory: outputs reflect the address of the previous cycle.
    logic [15:0] mem [0:16383];
    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 16'd0;
        bus.mem_douta = 16'd0;
        bus.mem_doutb = 16'd0;
    end
    always @(posedge clk) begin
        if (bus.mem_wea) mem[bus.mem_addr[13:0]] <= bus.mem_din;
        bus.mem_douta <= mem[bus.mem_addr[13:0]];
        bus.mem_doutb <= mem[14'(bus.mem_addr[13:0] - 14'd1)];
    end

    typedef struct {
        logic [15:0] top;
        logic [15:0] second;
        logic        ovf;
        logic        unf;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] dat;
    } wr_t;

    rsp_t rsp_q[$];
    wr_t  wr_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (!reset && bus.rsp_valid) begin
            if (rsp_q.size() == 0) begin
                chk("unexpected_rsp_valid", 32'd1, 32'd0);
            end else begin
                rsp_t r;
                r = rsp_q.pop_front();
                chk("rsp_top",    32'(bus.rsp_top),    32'(r.top));
                chk("rsp_second", 32'(bus.rsp_second), 32'(r.second));
                chk("err_ovf",    32'(bus.err_ovf),    32'(r.ovf));
                chk("err_unf",    32'(bus.err_unf),    32'(r.unf));
                chk("rsp_latency_cycle", 32'(cyc), 32'(r.cyc));
            end
        end
    end

    // Memory write monitor.
    always @(negedge clk) begin
        if (!reset && bus.mem_wea) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_mem_wea", {16'd0, bus.mem_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                chk("mem_addr_write", 32'(bus.mem_addr), 32'(w.addr));
                chk("mem_din_write",  32'(bus.mem_din),  32'(w.dat));
            end
        end
    end

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) chk(nm, 32'(bus.req_ready), 32'd1);
    endtask

    // Issue one request (called at a negedge) with hand-computed expectations.
    // waddr < 0 means no memory write expected.
    task automatic issue(input logic [1:0] op, input logic [15:0] wd,
                         input logic [15:0] et, input logic [15:0] es,
                         input logic eo, input logic eu, input int lat, input int waddr);
        rsp_t r;
        wr_t  w;
        wait_ready("ready_timeout_before");
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        acc_ovf = acc_ovf | eo;
        acc_unf = acc_unf | eu;
        r.top    = et;
        r.second = es;
        r.ovf    = STICKY ? acc_ovf : eo;
        r.unf    = STICKY ? acc_unf : eu;
        r.cyc    = cyc + lat - 1;
        rsp_q.push_back(r);
        if (waddr >= 0) begin
            w.addr = 16'(waddr);
            w.dat  = wd;
            wr_q.push_back(w);
        end
        @(negedge clk);
        wait_ready("ready_timeout_after");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_wdata = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_depth",     32'(bus.depth),     32'd0);
        chk("idle_mem_addr",  32'(bus.mem_addr),  32'h3FFF);
        chk("idle_mem_wea",   32'(bus.mem_wea),   32'd0);
        chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
        chk("idle_rsp_top",   32'(bus.rsp_top),   32'd0);
        chk("idle_err",       {30'd0, bus.err_ovf, bus.err_unf}, 32'd0);

        // Two pushes land at slots 0 and 1.
        issue(PUSH, 16'hA5A5, 16'h0, 16'h0, 1'b0, 1'b0, 1, 0);
        issue(PUSH, 16'h1234, 16'h0, 16'h0, 1'b0, 1'b0, 1, 1);
        chk("depth_after_push2", 32'(bus.depth), 32'd2);
        chk("addr_after_push2",  32'(bus.mem_addr), 32'd1);

        issue(PEEK2, 16'h0, 16'h1234, 16'hA5A5, 1'b0, 1'b0, 2, -1);
        chk("depth_after_peek2", 32'(bus.depth), 32'd2);
        issue(POP2, 16'h0, 16'h1234, 16'hA5A5, 1'b0, 1'b0, 2, -1);
        chk("depth_after_pop2", 32'(bus.depth), 32'd0);
        chk("addr_after_pop2",  32'(bus.mem_addr), 32'h3FFF);
        chk("rsp_hold_top",     32'(bus.rsp_top), 32'h1234);

        // Underflow cases.
        issue(POP, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1, -1);
        chk("depth_after_unf", 32'(bus.depth), 32'd0);
        chk("unf_after_idle",  32'(bus.err_unf), 32'(STICKY));
        issue(PUSH, 16'h0BEE, 16'h0, 16'h0, 1'b0, 1'b0, 1, 0);
        issue(PEEK2, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1, -1);
        chk("depth_after_peek_unf", 32'(bus.depth), 32'd1);
        issue(POP, 16'h0, 16'h0BEE, 16'h0, 1'b0, 1'b0, 2, -1);
        chk("depth_after_pop", 32'(bus.depth), 32'd0);

        // Fill to DEPTH=4, then overflow.
        for (int i = 0; i < 4; i++)
            issue(PUSH, 16'(i + 1), 16'h0, 16'h0, 1'b0, 1'b0, 1, i);
        chk("depth_full", 32'(bus.depth), 32'd4);
        issue(PUSH, 16'h0005, 16'h0, 16'h0, 1'b1, 1'b0, 1, -1);
        chk("depth_after_ovf", 32'(bus.depth), 32'd4);
        chk("ovf_after_idle",  32'(bus.err_ovf), 32'(STICKY));
        issue(POP, 16'h0, 16'h0004, 16'h0, 1'b0, 1'b0, 2, -1);
        issue(POP2, 16'h0, 16'h0003, 16'h0002, 1'b0, 1'b0, 2, -1);
        chk("depth_after_drain", 32'(bus.depth), 32'd1);

        // Reset while a POP sits in READ: aborted, no response.
        bus.req_valid = 1'b1;
        bus.req_op    = POP;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("busy_in_read", 32'(bus.req_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_depth",     32'(bus.depth),     32'd0);
        acc_ovf = 1'b0;
        acc_unf = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
        chk("post_rst_addr",  32'(bus.mem_addr),  32'h3FFF);
        chk("post_rst_err",   {30'd0, bus.err_ovf, bus.err_unf}, 32'd0);

        issue(PUSH, 16'h0077, 16'h0, 16'h0, 1'b0, 1'b0, 1, 0);
        chk("depth_final", 32'(bus.depth), 32'd1);

        repeat (4) @(negedge clk);
        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        chk("wr_queue_drained",  32'(wr_q.size()),  32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
